// File: rtl/mips_pkg.sv
// Shared integer-datapath definitions: divider FSM states, divide function
// codes (contiguous with the ALU codes) and the datapath word width.
package mips_pkg;

  localparam int unsigned WORD = 32;

  localparam logic [4:0] FS_DIV  = 5'h1A;
  localparam logic [4:0] FS_DIVU = 5'h1B;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when there is no borrow.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;
  logic           borrow;
  logic           unused_trial_msb;

  assign partial = {rem, quo[WIDTH-1]};
  assign {borrow, trial} = {1'b0, partial} - {2'b00, divisor};

  // rem < divisor on entry, so an accepted difference always fits in WIDTH bits
  assign rem_next = borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~borrow};

  assign unused_trial_msb = trial[WIDTH];

endmodule

// File: rtl/div_32.sv
// Multi-cycle signed/unsigned restoring divider with start/done handshake.
// Optional DIV0_DETECT_EN: a zero divisor skips CALC/FIX and finishes in one cycle.
module div_32
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = WORD
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C,
  output logic             busy,
  output logic             done
);

  div_state_t       state, state_nx;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [5:0]       cnt;
  logic             sign_r, s_neg, t_neg;
  logic             last_step, div0_bypass, ovf;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  assign last_step = (cnt == 6'(WIDTH - 1));

`ifdef DIV0_DETECT_EN
  assign div0_bypass = (T == '0);
`else
  assign div0_bypass = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = div0_bypass ? DONE : CALC;
      CALC:    if (last_step) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Overflow is recognised after CALC: |T|==1 with T negative and a magnitude
  // quotient of 0x80000000 can only come from 0x80000000 / -1.
  assign ovf   = sign_r & s_neg & t_neg & (dvs == WIDTH'(1)) &
                 (quo == {1'b1, {(WIDTH-1){1'b0}}});
  assign q_fix = (sign_r & (s_neg ^ t_neg)) ? -quo : quo;
  assign r_fix = (sign_r & s_neg) ? -rem : rem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      sign_r <= 1'b0;
      s_neg  <= 1'b0;
      t_neg  <= 1'b0;
      Y_hi   <= '0;
      Y_lo   <= '0;
      N      <= 1'b0;
      Z      <= 1'b1;
      V      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          sign_r <= sign;
          s_neg  <= S[WIDTH-1];
          t_neg  <= T[WIDTH-1];
          quo    <= (sign & S[WIDTH-1]) ? -S : S;
          dvs    <= (sign & T[WIDTH-1]) ? -T : T;
          rem    <= '0;
          cnt    <= '0;
          if (div0_bypass) begin
            Y_lo <= '1;
            Y_hi <= S;
            N    <= 1'b1;
            Z    <= 1'b0;
            V    <= 1'b1;
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          Y_lo <= q_fix;
          Y_hi <= r_fix;
          N    <= q_fix[WIDTH-1];
          Z    <= (q_fix == '0);
          V    <= ovf | (dvs == '0);
        end
        default: ;
      endcase
    end
  end

  assign C    = 1'b0;
  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule
